// File: rtl/svga_pkg.sv
// Shared types and default 800x600@60 timing for the SVGA raster generator.
package svga_pkg;

    typedef struct packed {
        logic       hpol;
        logic       vpol;
        logic [1:0] shift;
    } svga_cfg_t;

    localparam svga_cfg_t SVGA_CFG_RESET = '{hpol: 1'b1, vpol: 1'b1, shift: 2'd0};

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FRONT  = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BACK   = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FRONT  = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BACK   = 23;
    localparam int SVGA_CLK_DIV  = 1;
    localparam int SVGA_CNT_W    = 11;

endpackage

// File: rtl/svga_timing_gen_if.sv
// Runtime configuration write port: polarity and coordinate downscale.
interface svga_timing_gen_if;

    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_hpol;
    logic       cfg_vpol;
    logic [1:0] cfg_shift;

    modport master (output cfg_valid, cfg_hpol, cfg_vpol, cfg_shift, input cfg_ready);
    modport slave  (input cfg_valid, cfg_hpol, cfg_vpol, cfg_shift, output cfg_ready);

endinterface

// File: rtl/svga_axis_counter.sv
// One raster axis: counts active/front/sync/back and decodes sync and blank.
module svga_axis_counter #(
    parameter int ACTIVE = 800,
    parameter int FRONT  = 40,
    parameter int SYNC   = 128,
    parameter int BACK   = 88,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_raw,
    output logic         blank
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FRONT + SYNC);

    if (FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_porch
        $fatal(1, "svga_axis_counter: porch and sync widths must be >= 1");
    end
    if ((TOTAL - 1) >= (1 << W)) begin : g_bad_width
        $fatal(1, "svga_axis_counter: W too narrow for TOTAL-1");
    end

    // wrap means "this tick moves the counter from the last position back to 0".
    assign wrap     = tick && (count == LAST);
    assign sync_raw = (count >= SYNC_START) && (count < SYNC_END);
    assign blank    = (count >= ACT_END);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr || wrap) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/svga_timing_gen.sv
// SVGA raster timing generator: prescaler, H/V counters, double-buffered
// configuration and a fully registered output stage.
module svga_timing_gen
    import svga_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FRONT  = SVGA_H_FRONT,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BACK   = SVGA_H_BACK,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FRONT  = SVGA_V_FRONT,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BACK   = SVGA_V_BACK,
    parameter int CLK_DIV  = SVGA_CLK_DIV,
    parameter int CNT_W    = SVGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    svga_timing_gen_if.slave cfg,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             next_vertical,
    output logic             next_frame,
    output logic [CNT_W-1:0] x_pos,
    output logic [CNT_W-1:0] y_pos
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $fatal(1, "svga_timing_gen: CLK_DIV must be >= 1");
    end

    logic [PW-1:0]    pre;
    logic             pix_tick;
    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap, h_sync_raw, v_sync_raw, h_blank, v_blank;
    logic             visible, cfg_wr;
    svga_cfg_t        active_cfg, pending_cfg, wr_cfg;
    logic             pending_valid;

    // Gating the tick with enable keeps strobes and the config wrap quiet while stopped.
    assign pix_tick = enable && (pre == PRE_LAST);
    assign visible  = !h_blank && !v_blank;
    assign cfg_wr   = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_cfg   = '{hpol: cfg.cfg_hpol, vpol: cfg.cfg_vpol, shift: cfg.cfg_shift};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (!enable || pix_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    svga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(CNT_W)
    ) u_h (
        .clk(clk), .reset_n(reset_n), .tick(pix_tick), .clr(!enable),
        .count(h_count), .wrap(h_wrap), .sync_raw(h_sync_raw), .blank(h_blank)
    );

    svga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(CNT_W)
    ) u_v (
        .clk(clk), .reset_n(reset_n), .tick(h_wrap), .clr(!enable),
        .count(v_count), .wrap(v_wrap), .sync_raw(v_sync_raw), .blank(v_blank)
    );

    // The frame-wrap cycle promotes the pending slot; a write in that same
    // cycle bypasses the slot and takes effect directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg.cfg_ready <= 1'b0;
            active_cfg    <= SVGA_CFG_RESET;
            pending_cfg   <= SVGA_CFG_RESET;
            pending_valid <= 1'b0;
        end else begin
            cfg.cfg_ready <= 1'b1;
            if (v_wrap) begin
                pending_valid <= 1'b0;
                if (cfg_wr) begin
                    active_cfg <= wr_cfg;
                end else if (pending_valid) begin
                    active_cfg <= pending_cfg;
                end
            end else if (cfg_wr) begin
                pending_cfg   <= wr_cfg;
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync         <= 1'b0;
            vsync         <= 1'b0;
            hblank        <= 1'b1;
            vblank        <= 1'b1;
            de            <= 1'b0;
            next_vertical <= 1'b0;
            next_frame    <= 1'b0;
            x_pos         <= '0;
            y_pos         <= '0;
        end else if (!enable) begin
            hsync         <= !active_cfg.hpol;
            vsync         <= !active_cfg.vpol;
            hblank        <= 1'b1;
            vblank        <= 1'b1;
            de            <= 1'b0;
            next_vertical <= 1'b0;
            next_frame    <= 1'b0;
            x_pos         <= '0;
            y_pos         <= '0;
        end else begin
            hsync         <= h_sync_raw ~^ active_cfg.hpol;
            vsync         <= v_sync_raw ~^ active_cfg.vpol;
            hblank        <= h_blank;
            vblank        <= v_blank;
            de            <= visible;
            next_vertical <= h_wrap;
            next_frame    <= v_wrap;
            x_pos         <= visible ? (h_count >> active_cfg.shift) : '0;
            y_pos         <= visible ? (v_count >> active_cfg.shift) : '0;
        end
    end

endmodule

// File: tb/tb_svga_timing_gen.sv
// Directed bench for svga_timing_gen on a 16x8 raster, CLK_DIV 1 and 3.
module tb_svga_timing_gen;

    localparam int W = 5;
    localparam int N = 800;

    logic clk = 1'b0;
    logic rst_n;
    logic en1, en3;
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;

    svga_timing_gen_if cfg1 ();
    svga_timing_gen_if cfg3 ();

    logic         hs1, vs1, hb1, vb1, de1, nv1, nf1;
    logic [W-1:0] x1, y1;
    logic         hs3, vs3, hb3, vb3, de3, nv3, nf3;
    logic [W-1:0] x3, y3;

    logic         r_hs1 [1:N];
    logic         r_vs1 [1:N];
    logic         r_de1 [1:N];
    logic         r_nv1 [1:N];
    logic         r_nf1 [1:N];
    logic [W-1:0] r_x1  [1:N];
    logic [W-1:0] r_y1  [1:N];
    logic         r_nv3 [1:N];
    logic         r_nf3 [1:N];
    logic [W-1:0] r_x3  [1:N];

    always #5 clk = ~clk;

    svga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .CLK_DIV(1), .CNT_W(W)
    ) dut1 (
        .clk(clk), .reset_n(rst_n), .enable(en1), .cfg(cfg1),
        .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1), .de(de1),
        .next_vertical(nv1), .next_frame(nf1), .x_pos(x1), .y_pos(y1)
    );

    svga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .CLK_DIV(3), .CNT_W(W)
    ) dut3 (
        .clk(clk), .reset_n(rst_n), .enable(en3), .cfg(cfg3),
        .hsync(hs3), .vsync(vs3), .hblank(hb3), .vblank(vb3), .de(de3),
        .next_vertical(nv3), .next_frame(nf3), .x_pos(x3), .y_pos(y3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int t);
        while (k < t) step();
    endtask

    task automatic write_cfg1(input logic hp, input logic vp, input logic [1:0] sh);
        cfg1.cfg_valid = 1'b1;
        cfg1.cfg_hpol  = hp;
        cfg1.cfg_vpol  = vp;
        cfg1.cfg_shift = sh;
        step();
        cfg1.cfg_valid = 1'b0;
    endtask

    // Count high samples of a recorded strobe within edges [lo, hi].
    function automatic int count_hi(input logic s [1:N], input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (s[i] === 1'b1) c++;
        return c;
    endfunction

    // Index of the n-th (1-based) high sample, 0 when absent.
    function automatic int nth_hi(input logic s [1:N], input int n);
        int c = 0;
        for (int i = 1; i <= N; i++) begin
            if (s[i] === 1'b1) begin
                c++;
                if (c == n) return i;
            end
        end
        return 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_nv;
        rst_n = 1'b0;
        en1 = 1'b1;
        en3 = 1'b1;
        cfg1.cfg_valid = 1'b0; cfg1.cfg_hpol = 1'b1; cfg1.cfg_vpol = 1'b1; cfg1.cfg_shift = 2'd0;
        cfg3.cfg_valid = 1'b0; cfg3.cfg_hpol = 1'b1; cfg3.cfg_vpol = 1'b1; cfg3.cfg_shift = 2'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_hsync", hs1, 0);
        check("rst_vsync", vs1, 0);
        check("rst_blank", {hb1, vb1}, 2'b11);
        check("rst_de", de1, 0);
        check("rst_strobes", {nv1, nf1}, 0);
        check("rst_xy", {x1, y1}, 0);
        check("rst_ready", cfg1.cfg_ready, 0);

        // Test 1/2: free-running capture; edge n shows pixel n-1 (CLK_DIV 1)
        rst_n = 1'b1;
        for (int n = 1; n <= N; n++) begin
            @(posedge clk);
            #1;
            r_hs1[n] = hs1; r_vs1[n] = vs1; r_de1[n] = de1;
            r_nv1[n] = nv1; r_nf1[n] = nf1; r_x1[n] = x1; r_y1[n] = y1;
            r_nv3[n] = nv3; r_nf3[n] = nf3; r_x3[n] = x3;
            if (n == 1) check("ready_after_rst", cfg1.cfg_ready, 1);
        end

        check("hs_first", nth_hi(r_hs1, 1), 11);
        check("hs_per_line", count_hi(r_hs1, 1, 16), 2);
        check("nv_first", nth_hi(r_nv1, 1), 16);
        check("nv_second", nth_hi(r_nv1, 2), 32);
        check("nv_count", count_hi(r_nv1, 1, 256), 16);
        check("nf_first", nth_hi(r_nf1, 1), 128);
        check("nf_second", nth_hi(r_nf1, 2), 256);
        check("de_per_frame", count_hi(r_de1, 1, 128), 32);
        check("de_l3p7", r_de1[56], 1);
        check("de_l4p0", r_de1[65], 0);
        check("de_l0p8", r_de1[9], 0);
        check("vs_first", nth_hi(r_vs1, 1), 81);
        check("vs_per_frame", count_hi(r_vs1, 1, 128), 16);
        check("x_p6", r_x1[7], 6);
        check("y_l2", r_y1[36], 2);

        check("div3_nv_first", nth_hi(r_nv3, 1), 48);
        check("div3_nv_second", nth_hi(r_nv3, 2), 96);
        check("div3_nv_count", count_hi(r_nv3, 1, 768), 16);
        check("div3_nf_first", nth_hi(r_nf3, 1), 384);
        check("div3_nf_second", nth_hi(r_nf3, 2), 768);
        check("div3_nf_count", count_hi(r_nf3, 1, 768), 2);
        check("div3_x_e19", r_x3[19], 6);
        check("div3_x_e21", r_x3[21], 6);
        check("div3_x_e22", r_x3[22], 7);

        // Realign dut1 to pixel (0,0): after this, edge k shows pixel k-1
        en1 = 1'b0;
        step();
        en1 = 1'b1;
        k = 0;

        // Test 3: hpol=0 written at vcount 2 waits for the frame wrap
        step_to(40);
        write_cfg1(1'b0, 1'b1, 2'd0);
        step_to(59); check("hpol_old_p58", hs1, 1);
        step_to(61); check("hpol_old_p60", hs1, 0);
        step_to(128);
        check("wrap_nf", nf1, 1);
        check("hpol_old_p127", hs1, 0);
        step_to(129); check("hpol_new_p128", hs1, 1);
        step_to(139); check("hpol_new_p138", hs1, 0);
        step_to(141); check("hpol_new_p140", hs1, 1);

        // Test 4: write in the wrap cycle applies directly
        step_to(255);
        write_cfg1(1'b0, 1'b1, 2'd1);
        step_to(263); check("shift1_x", x1, 3);
        step_to(290);
        write_cfg1(1'b1, 1'b1, 2'd0);
        write_cfg1(1'b0, 1'b1, 2'd2);
        step_to(311); check("pending_not_live", x1, 3);
        step_to(391); check("last_write_x", x1, 1);
        step_to(395); check("last_write_hs_p10", hs1, 0);
        step_to(397); check("last_write_hs_p12", hs1, 1);

        // Test 5: disable at hcount 5
        step_to(405);
        check("pre_dis_de", de1, 1);
        check("pre_dis_x", x1, 1);
        en1 = 1'b0;
        step();
        check("dis_de", de1, 0);
        check("dis_hsync", hs1, 1);
        check("dis_blank", {hb1, vb1}, 2'b11);
        check("dis_x", x1, 0);
        step(); step();
        check("dis_nv", nv1, 0);
        en1 = 1'b1;
        k = 0;
        first_nv = 0;
        while (k < 40 && first_nv == 0) begin
            step();
            if (nv1 === 1'b1) first_nv = k;
        end
        check("reen_nv_delay", first_nv, 16);

        // Test 6: async reset mid-frame with a pending write
        step_to(40);
        write_cfg1(1'b0, 1'b0, 2'd3);
        step_to(50);
        rst_n = 1'b0;
        #1;
        check("arst_sync", {hs1, vs1}, 0);
        check("arst_blank", {hb1, vb1}, 2'b11);
        check("arst_de_strobe", {de1, nv1, nf1}, 0);
        check("arst_xy", {x1, y1}, 0);
        check("arst_ready", cfg1.cfg_ready, 0);
        #2;
        rst_n = 1'b1;
        k = 0;
        step_to(10); check("post_rst_p9", hs1, 0);
        step_to(11); check("post_rst_p10", hs1, 1);
        step_to(135); check("pend_dropped_x", x1, 6);
        step_to(139); check("pend_dropped_hs", hs1, 1);
        step_to(209); check("pend_dropped_vs", vs1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
